// File: rtl/serial_thermo_to_binary.sv
// serial_thermo_to_binary
// Counts the ones of a thermometer code that arrives one bit per accepted
// beat, LSB first. The count and a captured negate flag form the address and
// select for the downstream two's-complement lookup. A 1 that arrives after a
// 0 marks the stream as malformed. The count is still reported, and err is set.
// The working count is BIN_W bits wide. This relies on THERM_LEN < 2**BIN_W.

module serial_thermo_to_binary #(
  parameter int THERM_LEN = 31,
  parameter int BIN_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_negate_in,
  input  logic             i_bit_valid,
  input  logic             i_therm_bit,
  output logic             o_busy,
  output logic [BIN_W-1:0] o_bin_out,
  output logic             o_neg_out,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [BIN_W-1:0] IDX_LAST = BIN_W'(THERM_LEN - 1);
  localparam logic [BIN_W-1:0] ONE      = BIN_W'(1);

  state_t           r_state;
  state_t           w_next_state;

  logic [BIN_W-1:0] r_count;
  logic [BIN_W-1:0] r_idx;
  logic             r_seen_zero;
  logic             r_err_work;
  logic             r_neg_work;

  logic [BIN_W-1:0] r_bin;
  logic             r_neg;
  logic             r_err;

  logic [BIN_W-1:0] w_count_next;
  logic             w_err_next;
  logic             w_accept;
  logic             w_last;

  assign w_accept     = (r_state == SHIFT) && i_bit_valid;
  assign w_last       = (r_idx == IDX_LAST);
  assign w_count_next = r_count + {{(BIN_W-1){1'b0}}, i_therm_bit};
  assign w_err_next   = r_err_work | (i_therm_bit & r_seen_zero);

  // State register; reset abandons any conversion in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: start only matters in IDLE, DONE always lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next_state = SHIFT;
      SHIFT:   if (w_accept && w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Working counters: cleared on an accepted start, advanced on each accepted bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_seen_zero <= 1'b0;
      r_err_work  <= 1'b0;
      r_neg_work  <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_seen_zero <= 1'b0;
      r_err_work  <= 1'b0;
      r_neg_work  <= i_negate_in;
    end else if (w_accept) begin
      r_count    <= w_count_next;
      r_err_work <= w_err_next;
      r_idx      <= r_idx + ONE;
      if (!i_therm_bit) begin
        r_seen_zero <= 1'b1;
      end
    end
  end

  // Result registers load on the same edge that enters DONE and hold otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin <= '0;
      r_neg <= 1'b0;
      r_err <= 1'b0;
    end else if (w_accept && w_last) begin
      r_bin <= w_count_next;
      r_neg <= r_neg_work;
      r_err <= w_err_next;
    end
  end

  assign o_busy    = (r_state != IDLE);
  assign o_done    = (r_state == DONE);
  assign o_bin_out = r_bin;
  assign o_neg_out = r_neg;
  assign o_err     = r_err;

endmodule

// File: tb/tb_serial_thermo_to_binary.sv
// Directed bench for serial_thermo_to_binary. It drives inputs on the
// falling edge and samples outputs there too, half a cycle away from the
// active rising edge.

module tb_serial_thermo_to_binary;

  localparam int THERM_LEN = 31;
  localparam int BIN_W     = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic             negateIn;
  logic             bitValid;
  logic             thermBit;
  logic             busy;
  logic [BIN_W-1:0] binOut;
  logic             negOut;
  logic             done;
  logic             err;

  int checks = 0;
  int errors = 0;

  int edges;
  bit earlyDone;
  bit sawDone;

  serial_thermo_to_binary #(
    .THERM_LEN(THERM_LEN),
    .BIN_W    (BIN_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_negate_in(negateIn),
    .i_bit_valid(bitValid),
    .i_therm_bit(thermBit),
    .o_busy     (busy),
    .o_bin_out  (binOut),
    .o_neg_out  (negOut),
    .o_done     (done),
    .o_err      (err)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: count it, and report it with the tag if it is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Accept a start carrying neg, then feed nBits bits of the code (bit 0
  // first). With gaps set, each bit is preceded by a bit_valid=0 cycle that
  // carries a junk 1. At bit pokeIdx, start is raised again with negate_in
  // flipped. The task returns the rising edges counted after the start edge
  // and whether done came up before the last bit.
  task automatic applyStimulus(input logic neg, input logic [THERM_LEN-1:0] bits,
                               input int nBits, input bit gaps, input int pokeIdx,
                               output int edgeCount, output bit early);
    @(negedge clk);
    start    = 1'b1;
    negateIn = neg;
    @(negedge clk);
    start     = 1'b0;
    edgeCount = 0;
    early     = 1'b0;
    for (int i = 0; i < nBits; i++) begin
      if (gaps) begin
        bitValid = 1'b0;
        thermBit = 1'b1;
        @(negedge clk);
        edgeCount++;
        if (done) early = 1'b1;
      end
      bitValid = 1'b1;
      thermBit = bits[i];
      if (i == pokeIdx) begin
        start    = 1'b1;
        negateIn = ~neg;
      end
      @(negedge clk);
      edgeCount++;
      start = 1'b0;
      if (done && i != nBits - 1) early = 1'b1;
    end
    bitValid = 1'b0;
    thermBit = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    negateIn = 1'b0;
    bitValid = 1'b0;
    thermBit = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_neg", 32'(negOut), 32'd0);
    checkOutput("rst_bin", 32'(binOut), 32'd0);

    $display("[TB] contiguous 13 ones then 18 zeros");
    applyStimulus(1'b0, 31'h0000_1FFF, THERM_LEN, 1'b0, -1, edges, earlyDone);
    checkOutput("nom_edges", 32'(edges), 32'd31);
    checkOutput("nom_early", 32'(earlyDone), 32'd0);
    checkOutput("nom_done", 32'(done), 32'd1);
    checkOutput("nom_busy", 32'(busy), 32'd1);
    checkOutput("nom_bin", 32'(binOut), 32'd13);
    checkOutput("nom_err", 32'(err), 32'd0);
    checkOutput("nom_neg", 32'(negOut), 32'd0);

    $display("[TB] 31 ones negated, then back-to-back 31 zeros");
    applyStimulus(1'b1, 31'h7FFF_FFFF, THERM_LEN, 1'b0, -1, edges, earlyDone);
    checkOutput("ones_done", 32'(done), 32'd1);
    checkOutput("ones_bin", 32'(binOut), 32'd31);
    checkOutput("ones_neg", 32'(negOut), 32'd1);
    checkOutput("ones_err", 32'(err), 32'd0);
    applyStimulus(1'b0, 31'h0000_0000, THERM_LEN, 1'b0, -1, edges, earlyDone);
    checkOutput("zeros_edges", 32'(edges), 32'd31);
    checkOutput("zeros_done", 32'(done), 32'd1);
    checkOutput("zeros_bin", 32'(binOut), 32'd0);
    checkOutput("zeros_err", 32'(err), 32'd0);
    checkOutput("zeros_neg", 32'(negOut), 32'd0);
    @(negedge clk);
    checkOutput("zeros_done_drop", 32'(done), 32'd0);
    checkOutput("zeros_busy_drop", 32'(busy), 32'd0);
    checkOutput("zeros_bin_hold", 32'(binOut), 32'd0);

    $display("[TB] gapped valid, three ones");
    applyStimulus(1'b0, 31'h0000_0007, THERM_LEN, 1'b1, -1, edges, earlyDone);
    checkOutput("gap_edges", 32'(edges), 32'd62);
    checkOutput("gap_early", 32'(earlyDone), 32'd0);
    checkOutput("gap_done", 32'(done), 32'd1);
    checkOutput("gap_bin", 32'(binOut), 32'd3);
    checkOutput("gap_err", 32'(err), 32'd0);

    $display("[TB] bubble 1,1,0,1 then zeros");
    applyStimulus(1'b0, 31'h0000_000B, THERM_LEN, 1'b0, -1, edges, earlyDone);
    checkOutput("bub_done", 32'(done), 32'd1);
    checkOutput("bub_bin", 32'(binOut), 32'd3);
    checkOutput("bub_err", 32'(err), 32'd1);
    @(negedge clk);
    checkOutput("bub_err_hold", 32'(err), 32'd1);

    $display("[TB] clean five ones with a start poke mid-shift");
    applyStimulus(1'b0, 31'h0000_001F, THERM_LEN, 1'b0, 10, edges, earlyDone);
    checkOutput("poke_edges", 32'(edges), 32'd31);
    checkOutput("poke_early", 32'(earlyDone), 32'd0);
    checkOutput("poke_done", 32'(done), 32'd1);
    checkOutput("poke_bin", 32'(binOut), 32'd5);
    checkOutput("poke_err", 32'(err), 32'd0);
    checkOutput("poke_neg", 32'(negOut), 32'd0);

    $display("[TB] bit_valid pulses in idle");
    negateIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bitValid = 1'b1;
      thermBit = 1'b1;
      @(negedge clk);
      bitValid = 1'b0;
    end
    @(negedge clk);
    checkOutput("idle_bin", 32'(binOut), 32'd5);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_neg", 32'(negOut), 32'd0);

    $display("[TB] reset abort after ten ones");
    applyStimulus(1'b1, 31'h0000_03FF, 10, 1'b0, -1, edges, earlyDone);
    bitValid = 1'b1;
    thermBit = 1'b1;
    checkOutput("abort_busy_pre", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_bin", 32'(binOut), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    bitValid = 1'b0;
    thermBit = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    checkOutput("abort_bin_after", 32'(binOut), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
